rfphoenix_thread_reorder_buffer: RTL

//  Multi-thread reorder buffer: NTHREADS independent circular queues, each DEPTH deep.

---
 rtl/rfphoenix_thread_reorder_buffer_pkg.sv | 37 +++
 rtl/rfphoenix_thread_reorder_buffer_if.sv | 57 +++++
 rtl/rfphoenix_thread_reorder_buffer_rr_arbiter.sv | 34 +++
 rtl/rfphoenix_thread_reorder_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_thread_reorder_buffer_pkg.sv
// Shared types and constants for the multi-thread reorder buffer.
// Optional feature macro used by this slice: REB_FAULT_FLUSH_EN.
package rfphoenix_thread_reorder_buffer_pkg;

  localparam int REB_ENTRIES  = 4;
  localparam int NTHREADS_DEF = 4;
  localparam int DW_DEF       = 32;

  typedef logic [11:0] cause_code_t;
  typedef logic [5:0]  regspec_t;

  localparam cause_code_t FLT_NONE = 12'h000;
  localparam cause_code_t FLT_DBZ  = 12'h028;

  // Thread index width; a single-thread build still carries one bit.
  function automatic int thread_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TID_W  = thread_width(NTHREADS_DEF);
  localparam int SLOT_W = $clog2(REB_ENTRIES);

  typedef struct packed {
    logic [TID_W-1:0]  thread;
    logic [SLOT_W-1:0] slot;
  } rob_id_t;

  typedef struct packed {
    logic [TID_W-1:0]  thread;
    logic [31:0]       ip;
    regspec_t          rt;
    logic              rfwr;
    logic [DW_DEF-1:0] res;
    cause_code_t       cause;
  } rob_commit_t;

endpackage

// File: rtl/rfphoenix_thread_reorder_buffer_if.sv
// Alloc / done / flush / commit bundle of the thread reorder buffer.
// The slave modport is the buffer itself; the master side is the surrounding pipeline.
interface rfphoenix_thread_reorder_buffer_if
  import rfphoenix_thread_reorder_buffer_pkg::*;
#(
  parameter int NTHREADS = 4,
  parameter int DEPTH    = REB_ENTRIES,
  parameter int DW       = 32
) ();

  localparam int TW = thread_width(NTHREADS);
  localparam int SW = $clog2(DEPTH);

  logic                alloc_v_i;
  logic [TW-1:0]       alloc_thread_i;
  logic [31:0]         alloc_ip_i;
  regspec_t            alloc_rt_i;
  logic                alloc_rfwr_i;
  logic [NTHREADS-1:0] alloc_full_o;
  logic [TW+SW-1:0]    alloc_id_o;

  logic                done_v_i;
  logic [TW+SW-1:0]    done_id_i;
  logic [DW-1:0]       done_res_i;
  cause_code_t         done_cause_i;

  logic                flush_i;
  logic [TW-1:0]       flush_thread_i;

  logic                cmt_v_o;
  logic                cmt_rdy_i;
  logic [TW-1:0]       cmt_thread_o;
  logic [31:0]         cmt_ip_o;
  regspec_t            cmt_rt_o;
  logic                cmt_rfwr_o;
  logic [DW-1:0]       cmt_res_o;
  cause_code_t         cmt_cause_o;

  modport slave (
    input  alloc_v_i, alloc_thread_i, alloc_ip_i, alloc_rt_i, alloc_rfwr_i,
    output alloc_full_o, alloc_id_o,
    input  done_v_i, done_id_i, done_res_i, done_cause_i,
    input  flush_i, flush_thread_i,
    input  cmt_rdy_i,
    output cmt_v_o, cmt_thread_o, cmt_ip_o, cmt_rt_o, cmt_rfwr_o, cmt_res_o, cmt_cause_o
  );

  modport master (
    output alloc_v_i, alloc_thread_i, alloc_ip_i, alloc_rt_i, alloc_rfwr_i,
    input  alloc_full_o, alloc_id_o,
    output done_v_i, done_id_i, done_res_i, done_cause_i,
    output flush_i, flush_thread_i,
    output cmt_rdy_i,
    input  cmt_v_o, cmt_thread_o, cmt_ip_o, cmt_rt_o, cmt_rfwr_o, cmt_res_o, cmt_cause_o
  );

endinterface

// File: rtl/rfphoenix_thread_reorder_buffer_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr wins.
// Produces a one-hot grant, its index and a found flag.
module rfphoenix_thread_reorder_buffer_rr_arbiter
  import rfphoenix_thread_reorder_buffer_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = thread_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [TW-1:0] grant_idx,
  output logic          found
);

  logic [TW-1:0] cand;

  // Scan requesters starting at the priority pointer and keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = TW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rfphoenix_thread_reorder_buffer.sv
// Multi-thread reorder buffer: one circular queue per thread, in-order
// allocation, out-of-order completion, round-robin in-order retirement
// through a registered commit record.
// Optional: define REB_FAULT_FLUSH_EN to flush a thread's younger entries
// when a faulting head is loaded into the commit record.
module rfphoenix_thread_reorder_buffer
  import rfphoenix_thread_reorder_buffer_pkg::*;
#(
  parameter int NTHREADS = 4,
  parameter int DEPTH    = REB_ENTRIES,
  parameter int DW       = 32
) (
  input logic                            clk_i,
  input logic                            rst_ni,
  rfphoenix_thread_reorder_buffer_if.slave bus
);

  localparam int TW = thread_width(NTHREADS);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SW-1:0]    head_q  [NTHREADS];
  logic [SW-1:0]    tail_q  [NTHREADS];
  logic [CW-1:0]    count_q [NTHREADS];
  logic [DEPTH-1:0] valid_q [NTHREADS];
  logic [DEPTH-1:0] done_q  [NTHREADS];

  logic [31:0]      ip_q    [NTHREADS][DEPTH];
  regspec_t         rt_q    [NTHREADS][DEPTH];
  logic             rfwr_q  [NTHREADS][DEPTH];
  logic [DW-1:0]    res_q   [NTHREADS][DEPTH];
  cause_code_t      cause_q [NTHREADS][DEPTH];

  logic [TW-1:0]    rr_q;
  logic             cmt_v_q;
  logic [TW-1:0]    cmt_thread_q;
  logic [31:0]      cmt_ip_q;
  regspec_t         cmt_rt_q;
  logic             cmt_rfwr_q;
  logic [DW-1:0]    cmt_res_q;
  cause_code_t      cmt_cause_q;

  logic [NTHREADS-1:0] full;
  logic [NTHREADS-1:0] head_ready;
  logic [NTHREADS-1:0] grant;
  logic [TW-1:0]       grant_idx;
  logic                any_ready;
  logic                load;
  logic [NTHREADS-1:0] pop;
  logic [NTHREADS-1:0] fault_flush;
  logic [NTHREADS-1:0] flush_hit;
  logic [NTHREADS-1:0] alloc_take;
  logic [NTHREADS-1:0] done_take;
  logic [TW-1:0]       done_thread;
  logic [SW-1:0]       done_slot;
  logic [SW-1:0]       alloc_tail;

  logic [31:0]   sel_ip;
  regspec_t      sel_rt;
  logic          sel_rfwr;
  logic [DW-1:0] sel_res;
  cause_code_t   sel_cause;

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    return (s == SW'(DEPTH - 1)) ? '0 : s + SW'(1);
  endfunction

  assign done_thread = bus.done_id_i[TW+SW-1:SW];
  assign done_slot   = bus.done_id_i[SW-1:0];

  // Per-thread status: queue full and head entry ready to retire
  always_comb begin
    full       = '0;
    head_ready = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      full[t]       = (count_q[t] == CW'(DEPTH));
      head_ready[t] = valid_q[t][head_q[t]] && done_q[t][head_q[t]];
    end
  end

  rfphoenix_thread_reorder_buffer_rr_arbiter #(
    .N  (NTHREADS),
    .TW (TW)
  ) u_arb (
    .req       (head_ready),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (any_ready)
  );

  assign load = (!cmt_v_q || bus.cmt_rdy_i) && any_ready;

  // Decode which per-thread actions take effect this cycle; flush dominates alloc and done
  always_comb begin
    pop         = '0;
    fault_flush = '0;
    flush_hit   = '0;
    alloc_take  = '0;
    done_take   = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      pop[t] = load && grant[t];
`ifdef REB_FAULT_FLUSH_EN
      fault_flush[t] = pop[t] && (cause_q[t][head_q[t]] != FLT_NONE);
`else
      fault_flush[t] = 1'b0;
`endif
      flush_hit[t]  = (bus.flush_i && (bus.flush_thread_i == TW'(t))) || fault_flush[t];
      alloc_take[t] = bus.alloc_v_i && (bus.alloc_thread_i == TW'(t)) && !full[t] && !flush_hit[t];
      done_take[t]  = bus.done_v_i && (done_thread == TW'(t)) && (int'(done_slot) < DEPTH) &&
                      valid_q[t][done_slot] && !flush_hit[t];
    end
  end

  // Tail slot of the requested thread, used for the allocated id
  always_comb begin
    alloc_tail = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      if (bus.alloc_thread_i == TW'(t)) alloc_tail = tail_q[t];
    end
  end

  assign bus.alloc_full_o = full;
  assign bus.alloc_id_o   = {bus.alloc_thread_i, alloc_tail};

  // Head fields of the granted thread feeding the commit record
  always_comb begin
    sel_ip    = '0;
    sel_rt    = '0;
    sel_rfwr  = 1'b0;
    sel_res   = '0;
    sel_cause = FLT_NONE;
    for (int t = 0; t < NTHREADS; t++) begin
      if (grant[t]) begin
        sel_ip    = ip_q[t][head_q[t]];
        sel_rt    = rt_q[t][head_q[t]];
        sel_rfwr  = rfwr_q[t][head_q[t]];
        sel_res   = res_q[t][head_q[t]];
        sel_cause = cause_q[t][head_q[t]];
      end
    end
  end

  // Queue pointers, occupancy and valid/done flags for every thread
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NTHREADS; t++) begin
        head_q[t]  <= '0;
        tail_q[t]  <= '0;
        count_q[t] <= '0;
        valid_q[t] <= '0;
        done_q[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (flush_hit[t]) begin
          head_q[t]  <= '0;
          tail_q[t]  <= '0;
          count_q[t] <= '0;
          valid_q[t] <= '0;
          done_q[t]  <= '0;
        end else begin
          if (done_take[t]) done_q[t][done_slot] <= 1'b1;
          if (alloc_take[t]) begin
            valid_q[t][tail_q[t]] <= 1'b1;
            done_q[t][tail_q[t]]  <= 1'b0;
            tail_q[t]             <= next_slot(tail_q[t]);
          end
          if (pop[t]) begin
            valid_q[t][head_q[t]] <= 1'b0;
            head_q[t]             <= next_slot(head_q[t]);
          end
          case ({alloc_take[t], pop[t]})
            2'b10:   count_q[t] <= count_q[t] + CW'(1);
            2'b01:   count_q[t] <= count_q[t] - CW'(1);
            default: count_q[t] <= count_q[t];
          endcase
        end
      end
    end
  end

  // Entry payload storage; meaningful only while the matching valid bit is set
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < NTHREADS; t++) begin
      if (alloc_take[t]) begin
        ip_q[t][tail_q[t]]   <= bus.alloc_ip_i;
        rt_q[t][tail_q[t]]   <= bus.alloc_rt_i;
        rfwr_q[t][tail_q[t]] <= bus.alloc_rfwr_i;
      end
      if (done_take[t]) begin
        res_q[t][done_slot]   <= bus.done_res_i;
        cause_q[t][done_slot] <= bus.done_cause_i;
      end
    end
  end

  // Commit record and round-robin pointer; record holds while the consumer stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      cmt_v_q      <= 1'b0;
      cmt_thread_q <= '0;
      cmt_ip_q     <= '0;
      cmt_rt_q     <= '0;
      cmt_rfwr_q   <= 1'b0;
      cmt_res_q    <= '0;
      cmt_cause_q  <= FLT_NONE;
    end else if (load) begin
      cmt_v_q      <= 1'b1;
      cmt_thread_q <= grant_idx;
      cmt_ip_q     <= sel_ip;
      cmt_rt_q     <= sel_rt;
      cmt_rfwr_q   <= sel_rfwr;
      cmt_res_q    <= sel_res;
      cmt_cause_q  <= sel_cause;
      rr_q         <= (grant_idx == TW'(NTHREADS - 1)) ? '0 : grant_idx + TW'(1);
    end else if (bus.cmt_rdy_i) begin
      cmt_v_q <= 1'b0;
    end
  end

  assign bus.cmt_v_o      = cmt_v_q;
  assign bus.cmt_thread_o = cmt_thread_q;
  assign bus.cmt_ip_o     = cmt_ip_q;
  assign bus.cmt_rt_o     = cmt_rt_q;
  assign bus.cmt_rfwr_o   = cmt_rfwr_q;
  assign bus.cmt_res_o    = cmt_res_q;
  assign bus.cmt_cause_o  = cmt_cause_q;

endmodule
